// File: rtl/burst_scheduler.sv
// burst_scheduler: arbitrates UART and button fan commands into a FIFO and plays each as a burst of packet starts.
// Latency: uart_valid -> start_packet 2 cycles, button edge -> 5 cycles (FIFO empty, idle).
// Backpressure: none upstream; a request that finds the FIFO full is discarded and flagged on dropped.
module burst_scheduler #(
    parameter int unsigned BURST_COUNT = 220,
    parameter int unsigned TAIL_COUNT  = 3,
    parameter int unsigned PACKET_GAP  = 158400,
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter logic [2:0]  IDLE_CMD    = 3'd7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_valid,
    input  logic [2:0] uart_cmd,
    input  logic [3:0] btn_n,
    output logic       start_packet,
    output logic [2:0] cmd,
    output logic       busy,
    output logic       queue_full,
    output logic       dropped
);
    localparam int REM_W = ($clog2(BURST_COUNT + 1) > 8) ? $clog2(BURST_COUNT + 1) : 8;
    localparam int TMR_W = ($clog2(PACKET_GAP) > 18) ? $clog2(PACKET_GAP) : 18;
    localparam int AW    = $clog2(QUEUE_DEPTH);
    localparam int CW    = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FIRE,
        ST_GAP
    } state_t;

    // button synchronizer, edge detect and pending requests
    logic [3:0] btn_sync1;
    logic [3:0] btn_sync2;
    logic [3:0] btn_prev;
    logic [3:0] btn_fall;
    logic [3:0] pending;
    logic [3:0] pend_clr;

    // enqueue arbitration
    logic       req_vld;
    logic [2:0] req_dat;

    // command FIFO
    logic [2:0]    fifo_mem [QUEUE_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] fifo_cnt;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push_rdy;
    logic          push_vld;
    logic          pop_vld;
    logic [2:0]    head_dat;

    // burst sequencer
    state_t           state;
    state_t           state_nxt;
    logic [REM_W-1:0] remaining;
    logic [TMR_W-1:0] gap_tmr;
    logic [2:0]       cmd_reg;
    logic [REM_W-1:0] fire_rem;
    logic [2:0]       fire_cmd;

    assign btn_fall = btn_prev & ~btn_sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_sync1 <= '1;
            btn_sync2 <= '1;
            btn_prev  <= '1;
            pending   <= '0;
        end else begin
            btn_sync1 <= btn_n;
            btn_sync2 <= btn_sync1;
            btn_prev  <= btn_sync2;
            pending   <= (pending & ~pend_clr) | btn_fall;
        end
    end

    // UART wins; otherwise the lowest pending button. The pending bit clears even if the push is dropped.
    always_comb begin
        req_vld  = 1'b0;
        req_dat  = '0;
        pend_clr = '0;
        if (uart_valid && (uart_cmd <= 3'd4)) begin
            req_vld = 1'b1;
            req_dat = uart_cmd;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (pending[i] && !req_vld) begin
                    req_vld     = 1'b1;
                    req_dat     = 3'(i);
                    pend_clr[i] = 1'b1;
                end
            end
        end
    end

    // A pop in the same cycle frees the slot, so a push against a full FIFO still lands.
    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == CW'(QUEUE_DEPTH));
    assign push_rdy   = !fifo_full || pop_vld;
    assign push_vld   = req_vld && push_rdy;
    assign head_dat   = fifo_mem[rd_ptr];
    assign dropped    = req_vld && !push_rdy;
    assign queue_full = fifo_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push_vld) wr_ptr <= wr_ptr + AW'(1);
            if (pop_vld)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_vld, pop_vld})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_vld) fifo_mem[wr_ptr] <= req_dat;
    end

    always_comb begin
        state_nxt    = state;
        pop_vld      = 1'b0;
        start_packet = 1'b0;
        busy         = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop_vld   = 1'b1;
                    state_nxt = ST_FIRE;
                end
            end
            ST_FIRE: begin
                start_packet = 1'b1;
                busy         = 1'b1;
                state_nxt    = ST_GAP;
            end
            ST_GAP: begin
                busy = 1'b1;
                if (gap_tmr == '0) state_nxt = (remaining != '0) ? ST_FIRE : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Count and command of the packet about to fire, so cmd settles on the FIRE entry edge.
    assign fire_rem = (state == ST_IDLE) ? REM_W'(BURST_COUNT) : remaining;
    assign fire_cmd = (state == ST_IDLE) ? head_dat : cmd_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            remaining <= '0;
            gap_tmr   <= '0;
            cmd_reg   <= IDLE_CMD;
            cmd       <= IDLE_CMD;
        end else begin
            state <= state_nxt;
            if (pop_vld) begin
                cmd_reg   <= head_dat;
                remaining <= REM_W'(BURST_COUNT);
            end
            if (state == ST_FIRE) begin
                remaining <= remaining - REM_W'(1);
                gap_tmr   <= TMR_W'(PACKET_GAP - 2);
            end else if ((state == ST_GAP) && (gap_tmr != '0)) begin
                gap_tmr <= gap_tmr - TMR_W'(1);
            end
            if (state_nxt == ST_FIRE) begin
                cmd <= (fire_rem > REM_W'(TAIL_COUNT)) ? fire_cmd : IDLE_CMD;
            end else if (state_nxt == ST_IDLE) begin
                cmd <= IDLE_CMD;
            end
        end
    end

endmodule

// File: tb/tb_burst_scheduler.sv
// Bench for burst_scheduler: directed scenarios plus random traffic, all checked every cycle
// against a timeline model (command queue, pending buttons, burst start cycle arithmetic).
module tb_burst_scheduler;
    localparam int B    = 5;
    localparam int T    = 2;
    localparam int G    = 10;
    localparam int D    = 2;
    localparam int IDLE = 7;

    logic       clk        = 1'b0;
    logic       reset      = 1'b1;
    logic       uart_valid = 1'b0;
    logic [2:0] uart_cmd   = 3'd0;
    logic [3:0] btn_n      = 4'hF;
    logic       start_packet;
    logic [2:0] cmd;
    logic       busy;
    logic       queue_full;
    logic       dropped;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    burst_scheduler #(
        .BURST_COUNT(B),
        .TAIL_COUNT (T),
        .PACKET_GAP (G),
        .QUEUE_DEPTH(D),
        .IDLE_CMD   (3'd7)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .uart_valid  (uart_valid),
        .uart_cmd    (uart_cmd),
        .btn_n       (btn_n),
        .start_packet(start_packet),
        .cmd         (cmd),
        .busy        (busy),
        .queue_full  (queue_full),
        .dropped     (dropped)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // Reference model state
    int       cyc       = 0;
    int       q[$];
    int       ev_cyc[$];
    int       ev_bit[$];
    bit [3:0] pend      = '0;
    logic [3:0] prev_btn = 4'hF;
    bit       active    = 1'b0;
    int       bs        = 0;
    int       bcmd      = 0;
    int       pulse_cnt = 0;
    int       drop_cnt  = 0;

    always @(negedge clk) begin
        int e_start, e_busy, e_cmd, e_full, e_drop, k, req;
        cyc++;
        if (reset) begin
            q.delete();
            ev_cyc.delete();
            ev_bit.delete();
            pend     = '0;
            prev_btn = 4'hF;
            active   = 1'b0;
        end else begin
            // a button press becomes an arbitration candidate three cycles after the pin falls
            while (ev_cyc.size() > 0 && ev_cyc[0] == cyc) begin
                pend[ev_bit[0]] = 1'b1;
                void'(ev_cyc.pop_front());
                void'(ev_bit.pop_front());
            end
            for (int i = 0; i < 4; i++) begin
                if (prev_btn[i] && !btn_n[i]) begin
                    ev_cyc.push_back(cyc + 3);
                    ev_bit.push_back(i);
                end
            end
            prev_btn = btn_n;

            // burst occupies [bs, bs + B*G - 1]; pulse k at bs + k*G
            if (active && cyc >= bs + B * G) active = 1'b0;
            if (active) begin
                k       = (cyc - bs) / G;
                e_start = ((cyc - bs) % G == 0) ? 1 : 0;
                e_busy  = 1;
                e_cmd   = (B - k > T) ? bcmd : IDLE;
            end else begin
                e_start = 0;
                e_busy  = 0;
                e_cmd   = IDLE;
            end
            e_full = (q.size() == D) ? 1 : 0;
            if (!active && q.size() > 0) begin
                bcmd   = q.pop_front();
                active = 1'b1;
                bs     = cyc + 1;
            end

            req = -1;
            if (uart_valid && uart_cmd <= 3'd4) begin
                req = int'(uart_cmd);
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (req < 0 && pend[i]) begin
                        req     = i;
                        pend[i] = 1'b0;
                    end
                end
            end
            e_drop = 0;
            if (req >= 0) begin
                if (q.size() < D) q.push_back(req);
                else e_drop = 1;
            end

            check("start_packet", 32'(start_packet), e_start);
            check("cmd", 32'(cmd), e_cmd);
            check("busy", 32'(busy), e_busy);
            check("queue_full", 32'(queue_full), e_full);
            check("dropped", 32'(dropped), e_drop);
            if (start_packet === 1'b1) pulse_cnt++;
            if (dropped === 1'b1) drop_cnt++;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic uart(input logic [2:0] c);
        uart_valid = 1'b1;
        uart_cmd   = c;
        @(posedge clk);
        #1;
        uart_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    initial begin
        int p0, d0;
        idle(3);
        reset = 1'b0;
        @(negedge clk);
        check("rst_cmd", 32'(cmd), IDLE);
        check("rst_busy", 32'(busy), 0);
        check("rst_start", 32'(start_packet), 0);
        check("rst_full", 32'(queue_full), 0);
        check("rst_drop", 32'(dropped), 0);
        @(posedge clk);
        #1;

        // single UART burst
        p0 = pulse_cnt;
        uart(3'd2);
        idle(60);
        check("uart_burst_pulses", pulse_cnt - p0, B);

        // held button gives one burst
        p0 = pulse_cnt;
        btn_n[1] = 1'b0;
        idle(100);
        btn_n[1] = 1'b1;
        idle(10);
        check("btn_hold_pulses", pulse_cnt - p0, B);

        // UART and button in the same cycle: two back-to-back bursts
        p0 = pulse_cnt;
        uart_valid = 1'b1;
        uart_cmd   = 3'd0;
        btn_n[3]   = 1'b0;
        idle(1);
        uart_valid = 1'b0;
        idle(20);
        btn_n[3] = 1'b1;
        idle(110);
        check("seam_pulses", pulse_cnt - p0, 2 * B);

        // overflow during a burst
        p0 = pulse_cnt;
        d0 = drop_cnt;
        uart(3'd1);
        idle(5);
        uart(3'd2);
        uart(3'd3);
        uart(3'd4);
        idle(200);
        check("ovf_pulses", pulse_cnt - p0, 3 * B);
        check("ovf_drops", drop_cnt - d0, 1);

        // ignored command
        p0 = pulse_cnt;
        d0 = drop_cnt;
        uart(3'd6);
        idle(20);
        check("ign_pulses", pulse_cnt - p0, 0);
        check("ign_drops", drop_cnt - d0, 0);

        // reset in the gap after the third pulse
        p0 = pulse_cnt;
        uart(3'd4);
        idle(25);
        check("pre_rst_pulses", pulse_cnt - p0, 3);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        p0 = pulse_cnt;
        idle(60);
        check("post_rst_pulses", pulse_cnt - p0, 0);

        // random traffic
        for (int n = 0; n < 4000; n++) begin
            reset      = ($urandom_range(0, 1999) == 0);
            uart_valid = ($urandom_range(0, 19) == 0);
            uart_cmd   = 3'($urandom_range(0, 7));
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 59) == 0) btn_n[i] = ~btn_n[i];
            end
            idle(1);
        end
        reset      = 1'b0;
        uart_valid = 1'b0;
        btn_n      = 4'hF;
        idle(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
